// File: rtl/pll_reconfig_pkg.sv
// PLL reconfiguration slave: shared constants.
// Register map, FSM encoding and reset counter settings.
package pll_reconfig_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C      = 6'd5;
  localparam logic [5:0] ADDR_BW     = 6'd8;
  localparam logic [5:0] ADDR_CP     = 6'd9;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_LOCKWAIT = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef struct packed {
    logic [17:0] m;
    logic [17:0] n;
    logic [17:0] c;
    logic [3:0]  bw;
    logic [2:0]  cp;
  } pll_cfg_t;

  localparam pll_cfg_t RST_CFG = '{
    m:  18'h02525,
    n:  18'h20302,
    c:  18'h20302,
    bw: 4'd6,
    cp: 3'd3
  };

endpackage

// File: rtl/pll_reconfig_slave_if.sv
// PLL reconfiguration slave: management bus.
// Master drives address/strobes/data, slave returns read data.
interface pll_reconfig_slave_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_read;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;

  modport master (
    output mgmt_address, mgmt_read,
    output mgmt_write, mgmt_writedata,
    input  mgmt_readdata
  );

  modport slave (
    input  mgmt_address, mgmt_read,
    input  mgmt_write, mgmt_writedata,
    output mgmt_readdata
  );
endinterface

// File: rtl/pll_lock_timer.sv
// PLL reconfiguration slave: lock synchronizer and timeout.
// Counter runs only while en_i is high and saturates.
module pll_lock_timer #(
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic locked_i,
  input  logic en_i,
  output logic lock_ok,
  output logic lock_timeout
);

  logic [1:0]  sync_q;
  logic [15:0] cnt_q;

  // two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], locked_i};
  end

  // cycles spent waiting for lock, cleared when not waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               cnt_q <= '0;
    else if (!en_i)             cnt_q <= '0;
    else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign lock_ok      = sync_q[1];
  assign lock_timeout = cnt_q >= 16'(LOCK_TIMEOUT);

endmodule

// File: rtl/pll_reconfig_slave.sv
// PLL reconfiguration slave: register file and sequencer.
// Define PLL_RECONFIG_READBACK_EN to read back shadow settings.
module pll_reconfig_slave
  import pll_reconfig_pkg::*;
#(
  parameter int RECONF_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_reconfig_slave_if.slave   mgmt,
  input  logic                  pll_locked,
  output logic [17:0]           pll_m,
  output logic [17:0]           pll_n,
  output logic [17:0]           pll_c,
  output logic [3:0]            pll_bw,
  output logic [2:0]            pll_cp,
  output logic                  cfg_update,
  output logic                  busy
);

  logic [2:0]  state_q, state_d;
  logic [7:0]  shift_q;
  logic        mode_q;
  logic [1:0]  status_q;
  pll_cfg_t    shadow_q, stage_q, applied_q;
  logic        cfg_q;
  logic [31:0] rdata_q, rd_mux;
  logic        lock_ok, lock_timeout;
  logic        start_acc, shift_done, lock_exit;
  logic [5:0]  addr;
  logic [31:0] wd;
  logic        unused_wd;

  assign addr       = mgmt.mgmt_address;
  assign wd         = mgmt.mgmt_writedata;
  assign unused_wd  = ^wd[31:18];
  assign start_acc  = mgmt.mgmt_write &&
                      addr == ADDR_START &&
                      state_q == ST_IDLE;
  assign shift_done = state_q == ST_SHIFT &&
                      shift_q == 8'(RECONF_CYCLES - 1);
  assign lock_exit  = state_q == ST_LOCKWAIT &&
                      (lock_ok || lock_timeout);

  pll_lock_timer #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock (
    .clk          (clk),
    .reset_n      (reset_n),
    .locked_i     (pll_locked),
    .en_i         (state_q == ST_LOCKWAIT),
    .lock_ok      (lock_ok),
    .lock_timeout (lock_timeout)
  );

  // sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_acc)  state_d = ST_LOAD;
      ST_LOAD:                     state_d = ST_SHIFT;
      ST_SHIFT:    if (shift_done) state_d = ST_LOCKWAIT;
      ST_LOCKWAIT: if (lock_exit)  state_d = ST_DONE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // state register and shift-phase counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= (state_q == ST_SHIFT) ? shift_q + 8'd1 : '0;
    end
  end

  // mode and shadow settings, writable at any time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= 1'b0;
      shadow_q <= RST_CFG;
    end else if (mgmt.mgmt_write) begin
      unique case (1'b1)
        (addr == ADDR_MODE): mode_q      <= wd[0];
        (addr == ADDR_N):    shadow_q.n  <= wd[17:0];
        (addr == ADDR_M):    shadow_q.m  <= wd[17:0];
        (addr == ADDR_C):    shadow_q.c  <= wd[17:0];
        (addr == ADDR_BW):   shadow_q.bw <= wd[3:0];
        (addr == ADDR_CP):   shadow_q.cp <= wd[2:0];
        default: ;
      endcase
    end
  end

  // status: cleared on start, set with error flag on completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       status_q <= 2'b01;
    else if (start_acc) status_q <= 2'b00;
    else if (lock_exit) status_q <= {~lock_ok, 1'b1};
  end

  // staging snapshot, applied settings and update pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q   <= RST_CFG;
      applied_q <= RST_CFG;
      cfg_q     <= 1'b0;
    end else begin
      cfg_q <= shift_done;
      if (state_q == ST_LOAD) stage_q   <= shadow_q;
      if (shift_done)         applied_q <= stage_q;
    end
  end

  // read data mux
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (addr == ADDR_MODE):   rd_mux[0]    = mode_q;
      (addr == ADDR_STATUS): rd_mux[1:0]  = status_q;
`ifdef PLL_RECONFIG_READBACK_EN
      (addr == ADDR_N):      rd_mux[17:0] = shadow_q.n;
      (addr == ADDR_M):      rd_mux[17:0] = shadow_q.m;
      (addr == ADDR_C):      rd_mux[17:0] = shadow_q.c;
      (addr == ADDR_BW):     rd_mux[3:0]  = shadow_q.bw;
      (addr == ADDR_CP):     rd_mux[2:0]  = shadow_q.cp;
`endif
      default: ;
    endcase
  end

  // registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            rdata_q <= '0;
    else if (mgmt.mgmt_read) rdata_q <= rd_mux;
  end

  assign mgmt.mgmt_readdata = rdata_q;
  assign pll_m      = applied_q.m;
  assign pll_n      = applied_q.n;
  assign pll_c      = applied_q.c;
  assign pll_bw     = applied_q.bw;
  assign pll_cp     = applied_q.cp;
  assign cfg_update = cfg_q;
  assign busy       = state_q == ST_LOAD  ||
                      state_q == ST_SHIFT ||
                      state_q == ST_LOCKWAIT;

endmodule

// File: tb/tb_pll_reconfig_slave.sv
// Bench for pll_reconfig_slave: event-time reference model,
// per-edge scoreboard queue, independent monitor.
module tb_pll_reconfig_slave;

  localparam int R = 16;
  localparam int T = 1023;
  localparam logic [60:0] DEF_CFG =
    {18'h02525, 18'h20302, 18'h20302, 4'd6, 3'd3};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pll_locked = 1'b0;
  logic [17:0] pll_m, pll_n, pll_c;
  logic [3:0]  pll_bw;
  logic [2:0]  pll_cp;
  logic        cfg_update, busy;

  pll_reconfig_slave_if mif ();

  pll_reconfig_slave #(
    .RECONF_CYCLES (R),
    .LOCK_TIMEOUT  (T)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mgmt       (mif.slave),
    .pll_locked (pll_locked),
    .pll_m      (pll_m),
    .pll_n      (pll_n),
    .pll_c      (pll_c),
    .pll_bw     (pll_bw),
    .pll_cp     (pll_cp),
    .cfg_update (cfg_update),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int unsigned e;
    bit          rd;
    logic [31:0] rv;
    bit          busy;
    bit          cfg;
    logic [60:0] pll;
  } rec_t;
  rec_t sb[$];

  // reference model: registers plus event times of a reconfiguration
  logic [17:0] sh_m, sh_n, sh_c;
  logic [3:0]  sh_bw;
  logic [2:0]  sh_cp;
  logic        mode;
  logic [1:0]  st;
  logic [60:0] staged, applied;
  bit          active, err;
  int unsigned s_e, ap_e, dn_e;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sh_m = 18'h02525; sh_n = 18'h20302; sh_c = 18'h20302;
    sh_bw = 4'd6; sh_cp = 3'd3;
    mode = 1'b0; st = 2'b01;
    staged = DEF_CFG; applied = DEF_CFG;
    active = 0; err = 0;
    s_e = 0; ap_e = 0; dn_e = 0;
    sb.delete();
  endtask

  function automatic logic [31:0] rd_val(input logic [5:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      6'd0: v[0]   = mode;
      6'd1: v[1:0] = st;
`ifdef PLL_RECONFIG_READBACK_EN
      6'd3: v[17:0] = sh_n;
      6'd4: v[17:0] = sh_m;
      6'd5: v[17:0] = sh_c;
      6'd8: v[3:0]  = sh_bw;
      6'd9: v[2:0]  = sh_cp;
`endif
      default: ;
    endcase
    return v;
  endfunction

  task automatic step(input logic [5:0] a, input bit rd,
                      input bit wr, input logic [31:0] wd,
                      input bit lk);
    rec_t r;
    int unsigned e;
    bit acc;
    @(negedge clk);
    mif.mgmt_address = a;
    mif.mgmt_read = rd;
    mif.mgmt_write = wr;
    mif.mgmt_writedata = wd;
    acc = wr && a == 6'd2 && !active;
    if (acc) pll_locked = lk;
    e = cyc + 1;
    r.e = e;
    r.rd = rd;
    r.rv = rd_val(a);
    r.cfg = active && e == ap_e;
    if (active && e == s_e + 1) staged = {sh_m, sh_n, sh_c, sh_bw, sh_cp};
    if (r.cfg) applied = staged;
    if (active && e == dn_e) st = {err, 1'b1};
    if (active && e == dn_e + 1) active = 0;
    if (acc) begin
      active = 1;
      s_e = e;
      ap_e = e + 1 + R;
      err = !pll_locked;
      dn_e = ap_e + 1 + (err ? T : 0);
      st = 2'b00;
    end
    if (wr) begin
      case (a)
        6'd0: mode  = wd[0];
        6'd3: sh_n  = wd[17:0];
        6'd4: sh_m  = wd[17:0];
        6'd5: sh_c  = wd[17:0];
        6'd8: sh_bw = wd[3:0];
        6'd9: sh_cp = wd[2:0];
        default: ;
      endcase
    end
    r.busy = active && e < dn_e;
    r.pll = applied;
    sb.push_back(r);
  endtask

  task automatic idle(input int n, input logic [5:0] a, input bit rd);
    for (int i = 0; i < n; i++) step(a, rd, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d,
                    input bit lk);
    step(a, 1'b0, 1'b1, d, lk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    mif.mgmt_read = 1'b0;
    mif.mgmt_write = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_update", cfg_update, 1'b0);
    chk("rst_readdata", mif.mgmt_readdata, 32'h0);
    chk("rst_pll", {pll_m, pll_n, pll_c, pll_bw, pll_cp}, DEF_CFG);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // monitor: pops the record for each edge and compares outputs
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && sb.size() > 0 && sb[0].e == cyc) begin
        r = sb.pop_front();
        chk("busy", busy, r.busy);
        chk("cfg_update", cfg_update, r.cfg);
        chk("pll_out", {pll_m, pll_n, pll_c, pll_bw, pll_cp}, r.pll);
        if (r.rd) chk("readdata", mif.mgmt_readdata, r.rv);
      end
    end
  end

  logic [5:0] atab [12] = '{6'd0, 6'd1, 6'd2, 6'd2, 6'd3, 6'd4,
                            6'd5, 6'd8, 6'd9, 6'd6, 6'd12, 6'd63};

  initial begin
    mif.mgmt_address = '0;
    mif.mgmt_read = 1'b0;
    mif.mgmt_write = 1'b0;
    mif.mgmt_writedata = '0;
    model_reset();
    do_reset();

    step(6'd1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(6'd0, 1'b1, 1'b0, 32'h0, 1'b0);

    wr(6'd0, 32'h1, 1'b0);
    wr(6'd4, 32'hFFF2_2928, 1'b0);
    wr(6'd3, 32'h0002_0302, 1'b0);
    wr(6'd5, 32'h0002_0302, 1'b0);
    wr(6'd8, 32'h6, 1'b0);
    wr(6'd9, 32'h3, 1'b0);
    step(6'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    wr(6'd2, 32'h1, 1'b1);
    idle(26, 6'd1, 1'b1);

    wr(6'd2, 32'h1, 1'b1);
    idle(5, 6'd1, 1'b1);
    wr(6'd4, 32'h0000_0A0A, 1'b0);
    wr(6'd2, 32'h1, 1'b0);
    idle(25, 6'd1, 1'b1);
    wr(6'd2, 32'h1, 1'b1);
    idle(25, 6'd1, 1'b1);

    wr(6'd2, 32'h1, 1'b0);
    idle(1050, 6'd1, 1'b1);

    wr(6'd2, 32'h1, 1'b1);
    idle(8, 6'd1, 1'b1);
    do_reset();
    step(6'd1, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(2, 6'd1, 1'b0);

    wr(6'd4, 32'h0001_2345, 1'b0);
    step(6'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(2, 6'd0, 1'b0);

    for (int i = 0; i < 2500; i++) begin
      step(atab[$urandom_range(0, 11)],
           bit'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0,
           $urandom,
           $urandom_range(0, 9) != 0);
    end

    idle(4, 6'd1, 1'b1);
    @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
